// File: rtl/branch_page_sequencer.sv
// branch_page_sequencer
//
// Sits in front of the memory-page register. On a branch request it works out
// the shortest modular distance from the current page to the target page. It
// then walks the page register there with one increment or decrement pulse
// per cycle. Fetch is stalled (busy) for the whole walk. A one-cycle done pulse
// follows, and err reports whether the register actually landed on the target.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   br_valid       branch request valid
//   br_ready       high only in IDLE; request accepted on br_valid && br_ready
//   br_target_page destination page, captured on accept
//   cur_page       live value of the page register (sampled on accept and in WAIT)
//   flush          abandons a walk in STEP or WAIT (no done)
//   increment      one-cycle step-up pulse to the page register
//   decrement      one-cycle step-down pulse to the page register
//   busy           fetch stall, high in every non-IDLE state
//   done           one-cycle completion pulse
//   err            meaningful only with done; 1 = page register missed the target
//   dbg_state      current FSM state (IDLE=0, STEP=1, WAIT=2, DONE=3)
//
// Handshake: a request transfers on the rising edge where br_valid and
// br_ready are both high. br_ready depends only on registered state, so it
// never depends combinationally on br_valid. br_target_page and cur_page only
// need to be stable in the transfer cycle.

module branch_page_sequencer #(
    parameter int PAGE_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [PAGE_W-1:0] br_target_page,
    input  logic [PAGE_W-1:0] cur_page,
    input  logic              flush,
    output logic              increment,
    output logic              decrement,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Half the page space; a distance of exactly HALF is walked upward.
    localparam logic [PAGE_W-1:0] HALF = {1'b1, {(PAGE_W-1){1'b0}}};

    state_t            state, state_n;
    logic [PAGE_W-1:0] steps, steps_n;
    logic [PAGE_W-1:0] target, target_n;
    logic              dir_up, dir_up_n;
    logic              err_q, err_n;

    // Modular distance to the target and its complement (downward distance).
    logic [PAGE_W-1:0] diff;
    logic [PAGE_W-1:0] neg_diff;

    assign diff     = br_target_page - cur_page;
    assign neg_diff = '0 - diff;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            steps  <= '0;
            target <= '0;
            dir_up <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            steps  <= steps_n;
            target <= target_n;
            dir_up <= dir_up_n;
            err_q  <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        steps_n  = steps;
        target_n = target;
        dir_up_n = dir_up;
        err_n    = err_q;

        unique case (state)
            IDLE: begin
                // flush has no effect here; a request is still accepted.
                if (br_valid) begin
                    target_n = br_target_page;
                    err_n    = 1'b0;
                    if (diff == '0) begin
                        steps_n = '0;
                        state_n = WAIT;
                    end else if (diff <= HALF) begin
                        dir_up_n = 1'b1;
                        steps_n  = diff;
                        state_n  = STEP;
                    end else begin
                        dir_up_n = 1'b0;
                        steps_n  = neg_diff;
                        state_n  = STEP;
                    end
                end
            end

            STEP: begin
                if (flush) begin
                    state_n = IDLE;
                end else begin
                    steps_n = steps - 1'b1;
                    if (steps == 1) begin
                        state_n = WAIT;
                    end
                end
            end

            WAIT: begin
                // The last pulse has had a cycle to land in the page register.
                if (flush) begin
                    state_n = IDLE;
                end else begin
                    err_n   = (cur_page != target);
                    state_n = DONE;
                end
            end

            DONE: begin
                // flush is ignored so the completion pulse is never lost.
                state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

    // Outputs come from registered state and direction only.
    assign br_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign increment = (state == STEP) &&  dir_up;
    assign decrement = (state == STEP) && !dir_up;
    assign done      = (state == DONE);
    assign err       = (state == DONE) && err_q;
    assign dbg_state = state;

endmodule
